bpd_sat_add_arbiter: RTL and testbench
======================================

# bpd_sat_add_arbiter

Shares one saturating two's-complement adder among `N_REQ` requesters (check-node / variable-node update units) in the BP decode datapath. Each cycle it selects one pending request by round-robin, performs the saturating add, and delivers a registered result tagged with the requester index over a valid/ready handshake. Sits between the node-update units and the shared message-update adder resource.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `BIT`, 8, operand/result width, two's complement
- `ID_W`, 2, requester index width; must satisfy 2^ID_W >= N_REQ
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  per-requester request valid
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero
- `req_a`  in  N_REQ*BIT  operand A, requester i at bits [i*BIT +: BIT]
- `req_b`  in  N_REQ*BIT  operand B, same packing
- `res_valid`  out  1  result valid
- `res_ready`  in  1  downstream accept
- `res_data`  out  BIT  saturated sum
- `res_id`  out  ID_W  index of requester that produced `res_data`
- `res_sat`  out  1  saturation occurred for this result
- `sat_cnt`  out  16  saturation event count (only with `BPD_SAT_CNT_EN`)
- `sat_cnt_clr`  in  1  synchronous clear of `sat_cnt` (only with `BPD_SAT_CNT_EN`)

## Operation
- Output stage has two states: EMPTY (`res_valid`=0) and FULL (`res_valid`=1).
- Accept condition: `can_acc = !res_valid || res_ready`. Grant is issued only when `can_acc` and at least one `req_valid` is set.
- Round-robin: search starts at pointer `rr_ptr`, ascending with wrap at N_REQ-1 -> 0; first set `req_valid` wins. On grant g, `rr_ptr` <= (g+1) mod N_REQ. No grant -> `rr_ptr` unchanged.
- `req_ready[g]` asserted combinationally in the grant cycle; transfer on `req_valid[g] && req_ready[g]`. All other `req_ready` bits are 0. `req_ready` depends on `req_valid` and `res_ready`; requesters must not make `req_valid` depend on `req_ready`.
- Arithmetic: sum = A + B modulo 2^BIT. Overflow iff A and B share a sign bit and sum's sign differs. On overflow: result = 2^(BIT-1)-1 if A is non-negative, else -2^(BIT-1); `res_sat`=1. Otherwise result = sum, `res_sat`=0. Limits are derived from `BIT`, never hard-coded.
- On transfer: `res_data`, `res_id`, `res_sat` load, `res_valid` <= 1. If FULL and `res_ready`=1 with no grant: `res_valid` <= 0, data regs hold.
- While `res_valid && !res_ready`: all result outputs hold stable; no grant.
- A requester holding `req_valid` with no grant is not dropped; starvation bound is N_REQ-1 grants to others.

## Timing
- Latency: 1 cycle from transfer edge to `res_valid`.
- Throughput: 1 result/cycle with `res_ready` held high.
- Reset (async assert, sync deassert by system): `res_valid`=0, `res_data`=0, `res_id`=0, `res_sat`=0, `rr_ptr`=0, `sat_cnt`=0. `req_ready` all 0 during reset.
- Reset mid-operation: pending result is discarded; no partial state survives.

## Configuration
- `BPD_SAT_CNT_EN` defined: `sat_cnt` and `sat_cnt_clr` ports exist; `sat_cnt` increments by 1 on every transfer with saturation, sticks at 16'hFFFF, and `sat_cnt_clr` wins over a simultaneous increment (result 0 next cycle).
- Undefined: ports and counter are absent; all other behaviour identical.

## Structure
- Shared package `bpd_pkg`: saturation max/min functions parameterised by width, `sat_cnt` width constant (16).
- One sub-module: `bpd_sat_add_core` (combinational, `BIT` param): outputs sum and overflow flag; arbiter registers its outputs.
- Round-robin pick is local logic in the top module.

## Test plan
- Single requester 1, A=8'sd100, B=8'sd20, `res_ready`=1 -> next cycle `res_data`=120, `res_id`=1, `res_sat`=0.
- Saturation: A=100, B=100 -> `res_data`=8'h7F, `res_sat`=1; A=-100, B=-100 -> 8'h80, `res_sat`=1; A=127, B=-128 -> 8'hFF, `res_sat`=0.
- All four requesters valid continuously from reset, `res_ready`=1 -> `res_id` sequence 0,1,2,3,0,... one result per cycle.
- Back-pressure: `res_ready`=0 for 3 cycles while FULL -> outputs stable, all `req_ready`=0; on `res_ready`=1 next grant goes to pointer position.
- With `BPD_SAT_CNT_EN`: 3 saturating transfers -> `sat_cnt`=3; `sat_cnt_clr` coincident with a saturating transfer -> `sat_cnt`=0.
- Assert `rst_n`=0 while FULL -> `res_valid`=0 immediately (async), `rr_ptr`=0; first grant after release goes to lowest valid index.

Source files
------------

// File: rtl/bpd_pkg.sv
// Shared definitions for the BP decode datapath: saturation limits and the
// width of the saturation event counter.
package bpd_pkg;

    // Width of the optional saturation event counter.
    localparam int SAT_CNT_W = 16;

    // Largest two's-complement value of a w-bit word (0111...1), returned in
    // the low w bits of a 64-bit word; callers truncate to their width.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Smallest two's-complement value of a w-bit word (1000...0), returned in
    // the low w bits of a 64-bit word; callers truncate to their width.
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/bpd_sat_add_core.sv
// Combinational two's-complement adder that reports signed overflow.
// The wrapped sum is returned untouched; the caller picks the clamp value.
module bpd_sat_add_core #(
    parameter int BIT = 8
) (
    input  logic [BIT-1:0] a_i,
    input  logic [BIT-1:0] b_i,
    output logic [BIT-1:0] sum_o,
    output logic           ovf_o
);

    // Wrapped sum; overflow means both operands share a sign the sum lost.
    always_comb begin
        sum_o = a_i + b_i;
        ovf_o = (a_i[BIT-1] == b_i[BIT-1]) && (sum_o[BIT-1] != a_i[BIT-1]);
    end

endmodule

// File: rtl/bpd_sat_add_arbiter.sv
// Round-robin arbiter sharing one saturating adder among N_REQ requesters.
// One grant per cycle when the registered output stage can accept; the
// result is registered and tagged with the requester index.
// Optional feature: define BPD_SAT_CNT_EN to add the saturation event
// counter (sat_cnt) and its synchronous clear (sat_cnt_clr).
module bpd_sat_add_arbiter
    import bpd_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int BIT   = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*BIT-1:0]   req_a,
    input  logic [N_REQ*BIT-1:0]   req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [BIT-1:0]         res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_sat
`ifdef BPD_SAT_CNT_EN
    ,
    output logic [SAT_CNT_W-1:0]   sat_cnt,
    input  logic                   sat_cnt_clr
`endif
);

    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;
    logic            res_valid_q;
    logic            res_valid_d;
    logic [BIT-1:0]  res_data_q;
    logic [BIT-1:0]  res_data_d;
    logic [ID_W-1:0] res_id_q;
    logic [ID_W-1:0] res_id_d;
    logic            res_sat_q;
    logic            res_sat_d;

    logic            can_acc;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic            grant_en;
    logic [BIT-1:0]  a_sel;
    logic [BIT-1:0]  b_sel;
    logic [BIT-1:0]  sum_raw;
    logic            sum_ovf;
    logic [BIT-1:0]  sum_sat;

    // The output register can take a new result when empty or draining.
    assign can_acc = !res_valid_q || res_ready;

    // Rotating priority search: first valid requester at or after rr_ptr_q.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    // Gating with rst_n keeps every ready low while reset is held.
    assign grant_en = can_acc && grant_found && rst_n;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign a_sel = req_a[int'(grant_idx)*BIT +: BIT];
    assign b_sel = req_b[int'(grant_idx)*BIT +: BIT];

    bpd_sat_add_core #(
        .BIT (BIT)
    ) u_core (
        .a_i   (a_sel),
        .b_i   (b_sel),
        .sum_o (sum_raw),
        .ovf_o (sum_ovf)
    );

    // Clamp toward the sign of operand A when the add overflows.
    always_comb begin
        sum_sat = sum_raw;
        if (sum_ovf) begin
            sum_sat = a_sel[BIT-1] ? BIT'(sat_min(BIT)) : BIT'(sat_max(BIT));
        end
    end

    // Next-state for pointer and output stage: load on grant, drain on accept.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_sat_d   = res_sat_q;
        if (grant_en) begin
            rr_ptr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : ID_W'(grant_idx + 1'b1);
            res_valid_d = 1'b1;
            res_data_d  = sum_sat;
            res_id_d    = grant_idx;
            res_sat_d   = sum_ovf;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // Pointer and output registers; reset discards any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_sat_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_sat_q   <= res_sat_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_sat   = res_sat_q;

`ifdef BPD_SAT_CNT_EN
    logic [SAT_CNT_W-1:0] sat_cnt_q;
    logic [SAT_CNT_W-1:0] sat_cnt_d;

    // Count saturating transfers, sticking at all-ones; clear has priority.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_cnt_clr) begin
            sat_cnt_d = '0;
        end else if (grant_en && sum_ovf && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_bpd_sat_add_arbiter.sv
// Testbench for bpd_sat_add_arbiter: directed scenarios followed by random
// traffic, all checked against an arithmetic reference model.
// Define BPD_SAT_CNT_EN to also exercise the saturation counter.
module tb_bpd_sat_add_arbiter;
    import bpd_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    res_data;
    logic [IW-1:0]   res_id;
    logic            res_sat;
    logic            sat_cnt_clr;
`ifdef BPD_SAT_CNT_EN
    logic [SAT_CNT_W-1:0] sat_cnt;
    int                   m_cnt;
`endif

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    // Reference model state
    int  m_ptr;
    bit  m_valid;
    int  m_data;
    int  m_id;
    bit  m_sat;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bpd_sat_add_arbiter #(
        .N_REQ (N),
        .BIT   (W),
        .ID_W  (IW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_id      (res_id),
        .res_sat     (res_sat)
`ifdef BPD_SAT_CNT_EN
        ,
        .sat_cnt     (sat_cnt),
        .sat_cnt_clr (sat_cnt_clr)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = 0;
        m_id    = 0;
        m_sat   = 1'b0;
`ifdef BPD_SAT_CNT_EN
        m_cnt   = 0;
`endif
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic clr);
        int g;
        int s;
        int hi;
        int lo;
        bit sat;
        logic [N-1:0] exp_rdy;
        req_valid   = v;
        res_ready   = rdy;
        sat_cnt_clr = clr;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
        #1;
        g = -1;
        if (!m_valid || rdy) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        s = 0;
        sat = 1'b0;
        if (g >= 0) begin
            hi = (1 << (W - 1)) - 1;
            lo = -(1 << (W - 1));
            s  = int'($signed(op_a[g])) + int'($signed(op_b[g]));
            if (s > hi) begin s = hi; sat = 1'b1; end
            if (s < lo) begin s = lo; sat = 1'b1; end
            m_valid = 1'b1;
            m_data  = s & ((1 << W) - 1);
            m_id    = g;
            m_sat   = sat;
            m_ptr   = (g + 1) % N;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
`ifdef BPD_SAT_CNT_EN
        if (clr) m_cnt = 0;
        else if (g >= 0 && sat && m_cnt != 65535) m_cnt++;
`endif
        @(negedge clk);
        check_eq("res_valid", 32'(res_valid), 32'(m_valid));
        check_eq("res_data", 32'(res_data), 32'(m_data));
        check_eq("res_id", 32'(res_id), 32'(m_id));
        check_eq("res_sat", 32'(res_sat), 32'(m_sat));
`ifdef BPD_SAT_CNT_EN
        check_eq("sat_cnt", 32'(sat_cnt), 32'(m_cnt));
`endif
        $display("txn t=%0t v=%b rdy=%0b clr=%0b grant=%0d -> valid=%0b id=%0d data=%02h sat=%0b",
                 $time, v, rdy, clr, g, res_valid, res_id, res_data, res_sat);
    endtask

    task automatic set_op(input int idx, input int a, input int b);
        op_a[idx] = W'(a);
        op_b[idx] = W'(b);
    endtask

    initial begin
        logic [W-1:0] held_data;
        logic [IW-1:0] held_id;
        rst_n       = 1'b0;
        req_valid   = '1;
        res_ready   = 1'b1;
        sat_cnt_clr = 1'b0;
        req_a       = '0;
        req_b       = '0;
        for (int i = 0; i < N; i++) set_op(i, 0, 0);
        model_reset();

        // Reset state with every requester pending
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("rst_valid", 32'(res_valid), 32'd0);
        check_eq("rst_data", 32'(res_data), 32'd0);
        check_eq("rst_id", 32'(res_id), 32'd0);
        check_eq("rst_sat", 32'(res_sat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester 1, plain add
        set_op(1, 100, 20);
        cycle(4'b0010, 1'b1, 1'b0);
        check_eq("add_data", 32'(res_data), 32'd120);
        check_eq("add_id", 32'(res_id), 32'd1);
        check_eq("add_sat", 32'(res_sat), 32'd0);

        // Saturation corner cases through requester 1
        set_op(1, 100, 100);
        cycle(4'b0010, 1'b1, 1'b0);
        check_eq("sat_pos", 32'(res_data), 32'h7F);
        check_eq("sat_pos_flag", 32'(res_sat), 32'd1);
        set_op(1, -100, -100);
        cycle(4'b0010, 1'b1, 1'b0);
        check_eq("sat_neg", 32'(res_data), 32'h80);
        check_eq("sat_neg_flag", 32'(res_sat), 32'd1);
        set_op(1, 127, -128);
        cycle(4'b0010, 1'b1, 1'b0);
        check_eq("mixed_sign", 32'(res_data), 32'hFF);
        check_eq("mixed_flag", 32'(res_sat), 32'd0);
        cycle(4'b0000, 1'b1, 1'b0);

        // Fresh reset, then all requesters continuously: ids 0,1,2,3,0,...
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, i * 10, 1);
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            check_eq("rr_seq", 32'(res_id), 32'(k % N));
        end

        // Back-pressure: outputs frozen, no grants, then resume at pointer
        held_data = res_data;
        held_id   = res_id;
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, 1'b0, 1'b0);
            check_eq("bp_data", 32'(res_data), 32'(held_data));
            check_eq("bp_id", 32'(held_id), 32'(res_id));
        end
        cycle(4'b1111, 1'b1, 1'b0);
        check_eq("bp_resume_id", 32'(res_id), 32'((int'(held_id) + 1) % N));

`ifdef BPD_SAT_CNT_EN
        // Counter: clear, three saturating transfers, then clear wins
        cycle(4'b0000, 1'b1, 1'b1);
        set_op(2, 120, 120);
        for (int k = 0; k < 3; k++) cycle(4'b0100, 1'b1, 1'b0);
        check_eq("cnt_three", 32'(sat_cnt), 32'd3);
        cycle(4'b0100, 1'b1, 1'b1);
        check_eq("cnt_clr_wins", 32'(sat_cnt), 32'd0);
`endif

        // Random traffic with occasional stalls and extreme operands
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    op_a[i] = ($urandom_range(0, 1) == 1) ? 8'h7F : 8'h80;
                end else begin
                    op_a[i] = W'($urandom);
                end
                op_b[i] = W'($urandom);
            end
            cycle(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // Async reset while FULL: immediate clear, then lowest valid wins
        cycle(4'b1111, 1'b0, 1'b0);
        check_eq("full_before_rst", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(res_valid), 32'd0);
        check_eq("arst_data", 32'(res_data), 32'd0);
        check_eq("arst_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_op(2, 5, 6);
        cycle(4'b1100, 1'b1, 1'b0);
        check_eq("post_rst_id", 32'(res_id), 32'd2);
        check_eq("post_rst_data", 32'(res_data), 32'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
